// File: rtl/legv8_pkg.sv
// Shared LEGv8 types and encodings for the fetch path and its consumers.
package legv8_pkg;

  localparam int unsigned INSTR_WIDTH = 32;
  localparam int unsigned PC_SEL_W    = 2;

  typedef enum logic [PC_SEL_W-1:0] {
    PC_INC    = 2'b00,
    PC_BRANCH = 2'b01,
    PC_REG    = 2'b10,
    PC_HOLD   = 2'b11
  } pc_sel_e;

  typedef enum logic [1:0] {
    ST_RST   = 2'b00,
    ST_REQ   = 2'b01,
    ST_VALID = 2'b10
  } fetch_state_e;

endpackage

// File: rtl/legv8_next_pc.sv
// Combinational next-PC selection: sequential, PC-relative branch, register target, hold.
module legv8_next_pc
  import legv8_pkg::*;
#(
  parameter int unsigned ADDR_W = 64
) (
  input  logic [ADDR_W-1:0]   pc,
  input  logic [PC_SEL_W-1:0] pc_sel,
  input  logic [63:0]         branch_offset,
  input  logic [63:0]         reg_target,
  output logic [ADDR_W-1:0]   next_pc_c,
  output logic                misalign_c
);

  logic [ADDR_W-1:0] inc_pc;
  logic [ADDR_W-1:0] br_pc;
  logic [ADDR_W-1:0] reg_pc;

  // Modulo arithmetic: a negative offset wraps backward naturally.
  assign inc_pc = pc + ADDR_W'(4);
  assign br_pc  = pc + ADDR_W'(branch_offset << 2);
  assign reg_pc = ADDR_W'(reg_target) & ~ADDR_W'(3);

  always_comb begin
    next_pc_c  = pc;
    misalign_c = 1'b0;
    case (pc_sel_e'(pc_sel))
      PC_INC:    next_pc_c = inc_pc;
      PC_BRANCH: next_pc_c = br_pc;
      PC_REG: begin
        next_pc_c  = reg_pc;
        misalign_c = |reg_target[1:0];
      end
      PC_HOLD:   next_pc_c = pc;
      default:   next_pc_c = pc;
    endcase
  end

endmodule

// File: rtl/legv8_fetch_unit.sv
// Instruction fetch: PC register, req/ready memory read, instruction register.
module legv8_fetch_unit
  import legv8_pkg::*;
#(
  parameter int unsigned        ADDR_W   = 64,
  parameter logic [ADDR_W-1:0]  RESET_PC = '0
) (
  input  logic                   clock,
  input  logic                   reset,
  output logic [ADDR_W-1:0]      mem_addr,
  output logic                   mem_req,
  input  logic                   mem_ready,
  input  logic [INSTR_WIDTH-1:0] mem_rdata,
  input  logic                   advance,
  input  logic [PC_SEL_W-1:0]    pc_sel,
  input  logic [63:0]            branch_offset,
  input  logic [63:0]            reg_target,
  output logic [INSTR_WIDTH-1:0] instruction,
  output logic                   instr_valid,
  output logic [ADDR_W-1:0]      pc,
  output logic                   misalign
);

  fetch_state_e           state, state_nxt;
  logic [ADDR_W-1:0]      pc_nxt;
  logic [INSTR_WIDTH-1:0] instr_nxt;
  logic                   valid_nxt;
  logic                   req_nxt;
  logic                   misalign_nxt;
  logic [ADDR_W-1:0]      next_pc_c;
  logic                   misalign_c;

  legv8_next_pc #(.ADDR_W(ADDR_W)) u_next_pc (
    .pc            (pc),
    .pc_sel        (pc_sel),
    .branch_offset (branch_offset),
    .reg_target    (reg_target),
    .next_pc_c     (next_pc_c),
    .misalign_c    (misalign_c)
  );

  // The request address is the PC register itself, so it is stable while waiting.
  assign mem_addr = pc;

  always_ff @(posedge clock) begin
    if (reset) begin
      state       <= ST_RST;
      pc          <= RESET_PC;
      instruction <= '0;
      instr_valid <= 1'b0;
      mem_req     <= 1'b0;
      misalign    <= 1'b0;
    end else begin
      state       <= state_nxt;
      pc          <= pc_nxt;
      instruction <= instr_nxt;
      instr_valid <= valid_nxt;
      mem_req     <= req_nxt;
      misalign    <= misalign_nxt;
    end
  end

  // mem_req is registered from the next state so it is high exactly while in REQ.
  always_comb begin
    state_nxt    = state;
    pc_nxt       = pc;
    instr_nxt    = instruction;
    valid_nxt    = instr_valid;
    req_nxt      = 1'b0;
    misalign_nxt = misalign;
    case (state)
      ST_RST: begin
        state_nxt = ST_REQ;
        req_nxt   = 1'b1;
      end
      ST_REQ: begin
        req_nxt = 1'b1;
        if (mem_ready) begin
          instr_nxt = mem_rdata;
          valid_nxt = 1'b1;
          state_nxt = ST_VALID;
          req_nxt   = 1'b0;
        end
      end
      ST_VALID: begin
        if (advance) begin
          pc_nxt       = next_pc_c;
          valid_nxt    = 1'b0;
          state_nxt    = ST_REQ;
          req_nxt      = 1'b1;
          misalign_nxt = misalign | misalign_c;
        end
      end
      default: state_nxt = ST_RST;
    endcase
  end

endmodule

// File: doc/legv8_fetch_unit.md
# legv8_fetch_unit

Instruction fetch stage for the LEGv8 core: owns the program counter, issues word reads to instruction memory over a req/ready handshake, and holds the fetched word stable in an instruction register for `ControlUnit_LEGv8`. It sits directly upstream of the control unit. It advances the PC on a per-instruction `advance` strobe, using the next-PC selection the control unit derives from the current instruction and status.

## Interface
Parameters:
- `RESET_PC`, default 64'h0: PC value loaded on reset; bits [1:0] must be 0.
- `ADDR_W`, default 64: PC/address width.

Ports:
- `clock`  in  1  single system clock; all state updates on the rising edge.
- `reset`  in  1  synchronous, active-high.
- `mem_addr`  out  ADDR_W  instruction memory word address; equals `pc` while `mem_req` is high.
- `mem_req`  out  1  read request; held high until accepted.
- `mem_ready`  in  1  memory accepts the request and presents `mem_rdata` in the same cycle.
- `mem_rdata`  in  32  instruction word.
- `advance`  in  1  control unit has consumed the current instruction.
- `pc_sel`  in  2  next-PC source: 00 PC+4, 01 PC+(offset<<2), 10 reg_target, 11 hold PC (refetch).
- `branch_offset`  in  64  sign-extended word offset (control unit `constant`).
- `reg_target`  in  64  register value for BR.
- `instruction`  out  32  instruction register, to control unit `instruction`.
- `instr_valid`  out  1  `instruction` is fresh for the current `pc`.
- `pc`  out  ADDR_W  address of `instruction`.
- `misalign`  out  1  sticky: a `reg_target` with bits [1:0] ≠ 0 was taken.

## Operation
- FSM states: RST, REQ, VALID.
- RST is entered on `reset`. The next cycle always goes to REQ.
- REQ:
  - `mem_req`=1, `mem_addr`=`pc`.
  - On `mem_ready`=1: `instruction`<=`mem_rdata`, `instr_valid`<=1, go to VALID.
  - Otherwise stay in REQ. Address and request are held unchanged while `mem_ready` is low.
- VALID:
  - `mem_req`=0.
  - On `advance`=1: PC is updated per `pc_sel`, `instr_valid`<=0, go to REQ.
  - Otherwise hold everything.
- `advance` is ignored in RST and REQ; no queueing.
- Next-PC arithmetic is modulo 2^64, with no overflow flag:
  - PC+4 wraps from 64'hFFFF_FFFF_FFFF_FFFC to 0.
  - PC+(offset<<2) uses a signed offset, so a negative offset moves backward.
- `reg_target` bits [1:0] are forced to 0 in the new PC. If they were nonzero, `misalign`<=1; it stays set until reset.
- `pc_sel`=11 keeps the PC and re-reads the same address.
- `instruction` keeps its last value whenever `instr_valid`=0. Consumers gate on `instr_valid`.

## Timing
- Reset values: `pc`=`RESET_PC`, `instruction`=32'h0, `instr_valid`=0, `mem_req`=0, `misalign`=0, state RST.
- First request is driven the cycle after `reset` deasserts.
- Fetch latency with zero-wait memory: REQ in cycle n, `mem_ready` in cycle n, `instr_valid`=1 from cycle n+1. Each wait cycle of `mem_ready`=0 adds one cycle.
- Peak throughput is one instruction per 2 cycles (REQ, VALID).
- `advance` in VALID at cycle n gives the new `pc` and `mem_req`=1 at cycle n+1.
- Reset mid-request (REQ with `mem_ready` low, or `reset` and `mem_ready` together) means:
  - reset wins;
  - the returned data is discarded;
  - `mem_req` drops the next cycle.
- Memory must tolerate abandoned requests.
- `reset` and `advance` in the same cycle: reset wins.

## Structure
- Shared package `legv8_pkg`:
  - `pc_sel` encodings (`PC_INC`, `PC_BRANCH`, `PC_REG`, `PC_HOLD`);
  - fetch state enum;
  - `INSTR_WIDTH`=32.
- Sub-module `legv8_next_pc`: combinational next-PC mux and adders with the alignment check, reused later by the branch-predict stage.
- The fetch FSM, PC register and instruction register live in `legv8_fetch_unit`.

## Test plan
- Reset then zero-wait memory returning 32'h8B1F0040 (ADD):
  - `mem_addr`=0 in the first REQ cycle;
  - `instr_valid`=1 next cycle with `instruction`=32'h8B1F0040.
  - Then `advance` with `pc_sel`=00 gives `mem_addr`=4.
- `mem_ready` held low 3 cycles:
  - `mem_req` stays 1 and `mem_addr` stays constant;
  - `instr_valid` rises exactly 1 cycle after `mem_ready`.
- Branch: `pc`=64'h100, `pc_sel`=01, `branch_offset`=-2 gives next `pc`=64'hF8. Offset +1 from 64'hFFFF_FFFF_FFFF_FFFC gives `pc`=0.
- BR: `pc_sel`=10, `reg_target`=64'h2003 gives `pc`=64'h2000 and `misalign`=1. `misalign` stays set over later advances until reset.
- Reset asserted during REQ with `mem_ready`=1 in the same cycle: `instr_valid`=0, `instruction`=0 and `pc`=`RESET_PC` next cycle.
- `advance` pulsed during REQ is ignored: `pc` is unchanged after the fetch completes.
